// File: rtl/mp_add_seq_if.sv
// ============================================================================
// Module      : mp_add_seq_if
// Description : Operand stream, adder drive and result stream bundle for
//               mp_add_seq. Carries op_sub when MP_ADD_SEQ_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface mp_add_seq_if;
    logic        op_cin;
    logic        op_abort;
`ifdef MP_ADD_SEQ_SUB_EN
    logic        op_sub;
`endif
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_last;
    logic        out_cout;
    logic        busy;

    // Environment side: operand source, adder and result consumer.
    modport master (
`ifdef MP_ADD_SEQ_SUB_EN
        output op_sub,
`endif
        output op_cin, op_abort, in_valid, in_a, in_b, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_last, out_cout, busy
    );

    // Sequencer side.
    modport slave (
`ifdef MP_ADD_SEQ_SUB_EN
        input  op_sub,
`endif
        input  op_cin, op_abort, in_valid, in_a, in_b, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_last, out_cout, busy
    );
endinterface

`default_nettype wire

// File: rtl/mp_add_seq.sv
// ============================================================================
// Module      : mp_add_seq
// Description : Multi-precision add sequencer feeding a 16-bit adder one word
//               pair per beat, LSW first. Optional macro MP_ADD_SEQ_SUB_EN
//               adds A-B support via op_sub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mp_add_seq #(
    parameter int WORDS = 4,
    parameter int CW    = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mp_add_seq_if.slave  bus
);

    generate
        if ((WORDS < 2) || ((1 << CW) < WORDS)) begin : g_bad_params
            $error("mp_add_seq: illegal parameters WORDS=%0d CW=%0d", WORDS, CW);
        end
    endgenerate

    localparam logic [CW-1:0] C_LAST = CW'(WORDS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          r_out_valid;
    logic [15:0]   r_out_sum;
    logic          r_out_last;
    logic          r_out_cout;

    logic w_first;
    logic w_last;
    logic w_out_free;
    logic w_in_ready;
    logic w_accept;

    assign w_first    = (r_cnt == '0);
    assign w_last     = (r_cnt == C_LAST);
    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_in_ready = w_out_free && !bus.op_abort && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.add_a     = bus.in_a;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_last  = r_out_last;
    assign bus.out_cout  = r_out_cout;
    assign bus.busy      = (r_state == S_RUN);

`ifdef MP_ADD_SEQ_SUB_EN
    logic r_sub;
    logic w_sub;

    // Subtract mode is latched from word 0 and applies to every later word.
    assign w_sub       = w_first ? bus.op_sub : r_sub;
    assign bus.add_b   = w_sub ? ~bus.in_b : bus.in_b;
    assign bus.add_cin = w_first ? (w_sub | bus.op_cin) : r_carry;
`else
    assign bus.add_b   = bus.in_b;
    assign bus.add_cin = w_first ? bus.op_cin : r_carry;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else begin
            // Result register: load on accept, otherwise drain independently of abort.
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= bus.add_sum;
                r_out_last  <= w_last;
                r_out_cout  <= w_last ? bus.add_cout : 1'b0;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (bus.op_abort) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_carry <= 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
                r_sub   <= 1'b0;
`endif
            end else if (w_accept) begin
                r_carry <= bus.add_cout;
                r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
                r_state <= w_last ? S_IDLE : S_RUN;
`ifdef MP_ADD_SEQ_SUB_EN
                r_sub   <= w_last ? 1'b0 : w_sub;
`endif
            end
        end
    end

endmodule

`default_nettype wire
